// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and the oversampling ratio.
// No latency or backpressure; used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OVERSAMPLE = 16;

    // xor_in is the reduction XOR of the data word.
    function automatic logic parity_bit(input logic xor_in, input int mode);
        return (mode == PARITY_ODD) ? ~xor_in : xor_in;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter-side bundle: tick/start/data towards the transmitter, line and status back.
// No latency; no backpressure, a start strobe while busy is dropped.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            i_tx_start;
    logic [DBIT-1:0] i_data_in;
    logic            tx;
    logic            o_tx_busy;
    logic            tx_done_tick;

    modport master (
        output s_tick, i_tx_start, i_data_in,
        input  tx, o_tx_busy, tx_done_tick
    );

    modport slave (
        input  s_tick, i_tx_start, i_data_in,
        output tx, o_tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, SB_TICK-tick stop.
// Latency: tx leaves idle the cycle after an accepted start; frame = 16*(1+DBIT+par)+SB_TICK ticks.
// Backpressure: none; starts while busy (including the done cycle) are dropped, not queued.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_tx_if.slave bus
);

    localparam int              NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]      S_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      SB_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST  = NW'(DBIT - 1);
    localparam bit              HAS_PAR = (PARITY == PARITY_ODD) || (PARITY == PARITY_EVEN);

    uart_state_e     state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        par_d   = par_q;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_tx_start) begin
                    shift_d = bus.i_data_in;
                    par_d   = parity_bit(^bus.i_data_in, PARITY);
                    s_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.s_tick) begin
                    if (s_q == SB_LAST) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so the pin changes together with the state.
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.o_tx_busy    = (state_q != ST_IDLE);
    assign bus.tx_done_tick = done && !i_reset;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter paired with the existing receiver. It shares the same 16x-oversampling s_tick from the baud-rate generator.
- Accepts a parallel word with a one-cycle start strobe.
- Serialises it as 1 start bit, DBIT data bits (LSB first), an optional parity bit, then stop bits.
- Signals completion with a one-cycle done tick.
- Sits between the interface/ALU control FSM and the board TX pin.

Parameters:
DBIT, 8, number of data bits (5..8)
SB_TICK, 16, s_ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active-high
s_tick  input  1  baud-generator tick, 16 per bit period, one i_clk wide
i_tx_start  input  1  one-cycle strobe: load i_data_in and start a frame
i_data_in  input  DBIT  word to transmit, sampled only when a start is accepted
tx  output  1  serial line, idle high, registered
o_tx_busy  output  1  high whenever state != idle
tx_done_tick  output  1  one-cycle pulse at end of stop period

Behaviour:
- Reset (sampled on the i_clk edge while i_reset=1): state=idle, s/n counters=0, shift reg=0, tx=1, o_tx_busy=0, tx_done_tick=0. Reset mid-frame aborts the frame; tx=1 from the next edge and no done tick is issued.
- tx is driven from a register (tx_reg/tx_next); no combinational path to the pin.
- States:
  - idle: tx=1. If i_tx_start=1: shift_reg<=i_data_in, s<=0, state<=start. tx is 0 from the following cycle. Any s_tick in that same cycle is not counted.
  - start: tx=0. On each s_tick: if s==15 then s<=0, n<=0, state<=data; else s<=s+1.
  - data: tx=shift_reg[0]. On each s_tick: if s==15 then s<=0 and shift_reg<=shift_reg>>1. Then if n==DBIT-1 go to parity (PARITY!=0) or stop (PARITY==0); else n<=n+1. Otherwise s<=s+1.
  - parity: tx=parity bit computed from the word latched at start. Even: XOR of bits. Odd: inverted XOR. Held in a 1-bit register captured in idle. On s_tick with s==15: s<=0, state<=stop.
  - stop: tx=1. On s_tick with s==SB_TICK-1: state<=idle and tx_done_tick=1 for that cycle only. Otherwise s<=s+1.
- Each bit lasts exactly 16 s_ticks. Frame length in ticks is 16*(1+DBIT+(PARITY?1:0)) + SB_TICK.
- The s counter is 5 bits wide to cover SB_TICK up to 32. The n counter is clog2(DBIT) bits.
- Start and busy rules:
  - i_tx_start while busy (including the done-tick cycle) is ignored; it is not queued.
  - A start asserted the cycle after tx_done_tick is accepted, so back-to-back frames have no extra idle gap.
  - i_data_in changes after acceptance do not affect the frame in flight.
- s_tick low: all counters and tx hold.
- Unused PARITY values (3) behave as none.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: idle 3'b000, start 3'b001, data 3'b010, parity 3'b011, stop 3'b100
  - PARITY_NONE/ODD/EVEN constants
  - the 16-tick-per-bit constant (OVERSAMPLE=16), shared with the receiver
- No sub-module is needed; this is a single FSMD. The baud generator stays a separate, shared instance.

Test Plan:
- PARITY=0, s_tick every 4 clocks, send 0xA5. Required response: tx sequence 0, 1,0,1,0,0,1,0,1, 1, each bit exactly 64 clocks. tx_done_tick is a single pulse 160 ticks after start. o_tx_busy is high throughout.
- Loopback tx into the existing uart_rx, sending 0x00, 0xFF, 0x3C. Required response: rx o_data_out matches each word, and rx_done_tick fires once per frame.
- PARITY=2 with 0x07 -> parity bit 1. PARITY=1 with 0x07 -> parity bit 0. Frame is 176 ticks.
- Pulse i_tx_start again mid-data with 0x55, and in the tx_done_tick cycle. Required response: both are ignored and the original 0xA5 frame is unaltered. A start the cycle after done begins the next start bit with no gap.
- Assert i_reset during data bit 3. Required response: next edge tx=1, o_tx_busy=0, no tx_done_tick. A subsequent start of 0x81 transmits correctly.
- SB_TICK=32. Required response: stop high for 32 ticks, and done occurs at tick 176.
